// File: rtl/min_frame_stats_if.sv
// min_frame_stats_if: sample-in / frame-result-out handshake bundle for min_frame_stats.
interface min_frame_stats_if #(
  parameter int W = 8,
  parameter int FRAME_LEN = 16
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_min;
  logic [W-1:0]     out_max;
  logic [W+CNT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  modport master (
    output in_valid, in_data, in_flush, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_sum, out_count
  );
  modport slave (
    input  in_valid, in_data, in_flush, out_ready,
    output in_ready, out_valid, out_min, out_max, out_sum, out_count
  );
endinterface

// File: rtl/min_frame_stats.sv
// min_frame_stats: groups accepted samples into frames and reports min/max/sum/count per frame.
module min_frame_stats #(
  parameter int W = 8,
  parameter int FRAME_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  min_frame_stats_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int SW = W + CNT_W;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [W-1:0] acc_min, acc_max, n_min, n_max;
  logic [SW-1:0] acc_sum, n_sum;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic take, close;
  // n_* are the accumulator values after this edge, including any sample taken now
  always_comb begin
    take = bus.in_valid && bus.in_ready;
    n_min = !take ? acc_min : (state == IDLE || bus.in_data < acc_min) ? bus.in_data : acc_min;
    n_max = !take ? acc_max : (state == IDLE || bus.in_data > acc_max) ? bus.in_data : acc_max;
    n_sum = !take ? acc_sum : (state == IDLE) ? SW'(bus.in_data) : acc_sum + SW'(bus.in_data);
    n_cnt = !take ? cnt : (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
    close = (take && n_cnt == CNT_W'(FRAME_LEN)) || (bus.in_flush && (state == ACCUM || take));
    state_nx = (state == HOLD) ? (bus.out_ready ? IDLE : HOLD) : close ? HOLD : take ? ACCUM : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min <= '0;
      acc_max <= '0;
      acc_sum <= '0;
      cnt <= '0;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_min <= '0;
      bus.out_max <= '0;
      bus.out_sum <= '0;
      bus.out_count <= '0;
    end else begin
      bus.in_ready <= state_nx != HOLD;
      if (state == HOLD) begin
        if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          acc_min <= '0;
          acc_max <= '0;
          acc_sum <= '0;
          cnt <= '0;
        end
      end else begin
        acc_min <= n_min;
        acc_max <= n_max;
        acc_sum <= n_sum;
        cnt <= n_cnt;
        if (close) begin
          bus.out_valid <= 1'b1;
          bus.out_min <= n_min;
          bus.out_max <= n_max;
          bus.out_sum <= n_sum;
          bus.out_count <= n_cnt;
        end
      end
    end
  end
endmodule
